mem_access_stage: RTL

- MEM-stage data-memory controller; sits between the EX/MEM pipeline register and the MEM/WB register.
- Runs loads and stores over a variable-latency req/ack data-memory bus and stalls the upstream pipeline while an access is outstanding.
- Outputs feed the MEM/WB register directly: read data, ALU result, write-back controls and destination register.
- Non-memory instructions pass through in zero cycles with no stall.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_stage_pkg;

   // Access sequencer states; the encoding is visible on the debug port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Low address bits that must be zero for a word access.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   // WAIT cycles allowed without an acknowledge before a bus error is flagged.
   localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
//
// Handshake: the master raises Mem_req together with Mem_we/Mem_addr/Mem_wdata
// and holds all four stable until the slave acknowledges. Mem_ack is a single
// cycle pulse; Mem_rdata is only meaningful in the cycle Mem_ack is high.
// The master drops Mem_req on the edge that samples Mem_ack. An ack while no
// request is outstanding is ignored.
interface mem_access_stage_if #(
   parameter int word = 32
);
   import mem_stage_pkg::*;

   logic            Mem_req;
   logic            Mem_we;
   logic [word-1:0] Mem_addr;
   logic [word-1:0] Mem_wdata;
   logic [word-1:0] Mem_rdata;
   logic            Mem_ack;

   modport master (
      output Mem_req, Mem_we, Mem_addr, Mem_wdata,
      input  Mem_rdata, Mem_ack
   );

   modport slave (
      input  Mem_req, Mem_we, Mem_addr, Mem_wdata,
      output Mem_rdata, Mem_ack
   );

endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs loads/stores over a variable-latency req/ack bus,
// stalls the upstream pipeline while an access is outstanding, and feeds the
// MEM/WB register. Non-memory instructions pass through with no stall.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int word    = 32,
   parameter int rwidth  = 5,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              Clock,
   input  logic              Reset_n,
   // from EX/MEM
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              MEM_RegWrite_in,
   input  logic              MEM_MemtoReg_in,
   input  logic [word-1:0]   MEM_ALU_result_in,
   input  logic [word-1:0]   MEM_Write_data,
   input  logic [rwidth-1:0] MEM_MUX8_in,
   // data-memory bus
   mem_access_stage_if.master bus,
   // to the pipeline / MEM/WB
   output logic              Stall,
   output logic              MEM_RegWrite,
   output logic              MEM_MemtoReg,
   output logic [word-1:0]   MEM_ALU_result,
   output logic [rwidth-1:0] MEM_MUX8_out,
   output logic [word-1:0]   MEM_Data_memory_Read_data,
   output logic              Misalign,
   output logic              Bus_error,
   // debug view of the sequencer
   output state_t            dbg_state
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [word-1:0] addr_q, addr_d;
   logic [word-1:0] wdata_q, wdata_d;
   logic [word-1:0] rdata_q, rdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            berr_q, berr_d;

   logic mem_op;
   logic access;

   // Decode the request; a misaligned access is never sent to the bus.
   always_comb begin
      mem_op   = MEM_MemRead | MEM_MemWrite;
      Misalign = mem_op & ((MEM_ALU_result_in[1:0] & ALIGN_MASK) != 2'b00);
      access   = mem_op & ~Misalign;
   end

   // Next-state logic; DONE always returns to IDLE so one instruction is one access.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      berr_d  = berr_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d = WAIT;
               req_d   = 1'b1;
               we_d    = MEM_MemWrite;   // read+write together is a store
               addr_d  = MEM_ALU_result_in;
               wdata_d = MEM_Write_data;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (bus.Mem_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) rdata_d = bus.Mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               berr_d  = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            berr_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            berr_d  = 1'b0;
         end
      endcase
   end

   // Sequencer and bus registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         berr_q  <= berr_d;
      end
   end

   // Stall covers the issuing IDLE cycle and every WAIT cycle; write-back is
   // suppressed (a bubble) while stalled, on misalignment, and on bus error.
   always_comb begin
      Stall                     = (state_q == WAIT) | ((state_q == IDLE) & access);
      Bus_error                 = berr_q;
      MEM_RegWrite              = MEM_RegWrite_in & ~Stall & ~Misalign & ~berr_q;
      MEM_MemtoReg              = MEM_MemtoReg_in;
      MEM_ALU_result            = MEM_ALU_result_in;
      MEM_MUX8_out              = MEM_MUX8_in;
      MEM_Data_memory_Read_data = rdata_q;
      bus.Mem_req               = req_q;
      bus.Mem_we                = we_q;
      bus.Mem_addr              = addr_q;
      bus.Mem_wdata             = wdata_q;
      dbg_state                 = state_q;
   end

endmodule
